wb_inst_responder: RTL and testbench
====================================

WB_INST_RESPONDER -- requirements
Module: wb_inst_responder

Interface
REQ-001 SHALL have parameter DW, default 128, Wishbone data width (32, 64 or 128).
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, instruction FIFO entries (power of 2).
REQ-004 SHALL have parameter MEM_WORDS, default 16, DW-wide data memory words (power of 2).
REQ-005 SHALL have parameter WAIT_CYCLES, default 0, wait states inserted before ack (0..15).
REQ-006 SHALL have parameter NOP_WORD, default 32'hF0801003, filler instruction.
REQ-007 SHALL have ports:
  i_clk  in  1  clock, all logic on rising edge
  i_rst_n  in  1  asynchronous active-low reset
  i_wb_adr  in  AW  bus address
  i_wb_sel  in  DW/8  byte enables
  i_wb_we  in  1  write strobe
  i_wb_dat  in  DW  write data from master
  i_wb_cyc  in  1  cycle valid
  i_wb_stb  in  1  strobe
  o_wb_dat  out  DW  read data
  o_wb_ack  out  1  transfer acknowledge
  o_wb_err  out  1  transfer error
  i_data_base  in  AW  addresses >= this hit data memory, else instruction region
  i_inst_valid  in  1  push instruction
  i_inst  in  32  instruction word
  o_inst_ready  out  1  FIFO not full
  o_fifo_count  out  $clog2(FIFO_DEPTH+1)  occupied entries
  o_wr_valid  out  1  one-cycle pulse: data write committed
  o_wr_adr  out  AW  committed write address
  o_wr_dat  out  DW  committed write data

Function
REQ-008 SHALL implement FSM IDLE, WAIT, ACK; request = i_wb_cyc & i_wb_stb.
REQ-009 IDLE + request SHALL latch adr/sel/we/dat; go ACK if WAIT_CYCLES==0, else WAIT with counter = WAIT_CYCLES.
REQ-010 WAIT SHALL decrement counter each cycle; counter==1 -> ACK.
REQ-011 WAIT with i_wb_cyc low SHALL abort to IDLE: no ack, no pop, no write.
REQ-012 ACK SHALL assert o_wb_ack for exactly one cycle, then IDLE; read latency = WAIT_CYCLES+1 cycles after request.
REQ-013 Instruction read SHALL drive bits[31:0] = FIFO head (pop) if non-empty else NOP_WORD; all upper 32-bit lanes = NOP_WORD.
REQ-014 Instruction-region write SHALL be acked and discarded.
REQ-015 Data read SHALL return mem[(adr >> log2(DW/8)) mod MEM_WORDS].
REQ-016 Data write SHALL update only bytes with i_wb_sel set, in the ACK cycle, and pulse o_wr_valid with latched adr/dat.
REQ-017 o_wb_dat SHALL be registered, valid only while o_wb_ack/o_wb_err high, else hold previous value.
REQ-018 Push with FIFO full SHALL be dropped; o_inst_ready = (count < FIFO_DEPTH).
REQ-019 Simultaneous push and pop SHALL leave count unchanged, including at full (pop frees slot same cycle).
REQ-020 FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-021 i_rst_n low SHALL immediately force: FSM IDLE, counter 0, FIFO empty (count 0), data memory zero, o_wb_ack/o_wb_err/o_wr_valid 0, o_wb_dat 0, o_wr_adr/o_wr_dat 0.
REQ-022 Reset during WAIT or ACK SHALL abandon the transfer with no ack; deassertion SHALL resume in IDLE.

Configuration
REQ-023 Macro WB_RESP_ERR_INJECT_EN defined SHALL add input i_err_req (1 bit), sampled with request; when 1, ACK state drives o_wb_err instead of o_wb_ack, no pop, no write.
REQ-024 Macro undefined SHALL omit i_err_req and tie o_wb_err to 0.

Verification
REQ-025 DW=128, WAIT_CYCLES=0: push 32'hE3A01005, fetch adr 0 -> ack next cycle, o_wb_dat = {96'hF0801003F0801003F0801003, 32'hE3A01005}, count 1->0.
REQ-026 Empty FIFO fetch -> o_wb_dat lanes all 32'hF0801003, count stays 0.
REQ-027 WAIT_CYCLES=3, i_data_base=32'h100: write adr 32'h110, sel 16'h000F, dat lane0 32'hDEADBEEF -> ack 4 cycles after request, o_wr_valid pulse; read back 32'h110 -> lane0 32'hDEADBEEF, other bytes 0.
REQ-028 Push 9 words into depth 8 -> 9th dropped, o_inst_ready 0, count 8; push+fetch same cycle at full -> count stays 8.
REQ-029 WAIT_CYCLES=3, drop i_wb_cyc after 1 wait cycle -> no ack, FIFO count unchanged; reset asserted mid-WAIT -> ack 0 at once, count 0.
REQ-030 With WB_RESP_ERR_INJECT_EN, i_err_req=1 on fetch with 2 queued -> o_wb_err pulse, o_wb_ack 0, count stays 2.

Source files
------------

// File: rtl/wb_inst_responder.sv
// Wishbone slave that feeds queued instruction words (or a NOP filler) to a fetch master and
// serves a small byte-enabled data memory. Define WB_RESP_ERR_INJECT_EN to add the i_err_req input.
module wb_inst_responder #(
   parameter int          DW          = 128,
   parameter int          AW          = 32,
   parameter int          FIFO_DEPTH  = 8,
   parameter int          MEM_WORDS   = 16,
   parameter int          WAIT_CYCLES = 0,
   parameter logic [31:0] NOP_WORD    = 32'hF0801003
) (
   input  logic                              i_clk,
   input  logic                              i_rst_n,
   input  logic [AW-1:0]                     i_wb_adr,
   input  logic [DW/8-1:0]                   i_wb_sel,
   input  logic                              i_wb_we,
   input  logic [DW-1:0]                     i_wb_dat,
   input  logic                              i_wb_cyc,
   input  logic                              i_wb_stb,
   output logic [DW-1:0]                     o_wb_dat,
   output logic                              o_wb_ack,
   output logic                              o_wb_err,
   input  logic [AW-1:0]                     i_data_base,
   input  logic                              i_inst_valid,
   input  logic [31:0]                       i_inst,
   output logic                              o_inst_ready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_fifo_count,
   output logic                              o_wr_valid,
   output logic [AW-1:0]                     o_wr_adr,
   output logic [DW-1:0]                     o_wr_dat
`ifdef WB_RESP_ERR_INJECT_EN
   ,
   input  logic                              i_err_req
`endif
);

   localparam int SW    = DW / 8;
   localparam int LANES = DW / 32;
   localparam int CW    = $clog2(FIFO_DEPTH + 1);
   localparam int PW    = $clog2(FIFO_DEPTH);
   localparam int MW    = $clog2(MEM_WORDS);
   localparam int BOFF  = $clog2(SW);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_ACK = 2'd2} state_t;

   state_t          r_state;
   logic [3:0]      r_cnt;
   logic [AW-1:0]   r_adr;
   logic [SW-1:0]   r_sel;
   logic            r_we;
   logic [DW-1:0]   r_dat;
   logic [31:0]     r_fifo [FIFO_DEPTH];
   logic [PW-1:0]   r_rd_ptr;
   logic [PW-1:0]   r_wr_ptr;
   logic [CW-1:0]   r_count;
   logic [DW-1:0]   r_mem [MEM_WORDS];
   logic            r_wb_ack;
   logic [DW-1:0]   r_wb_dat;
   logic            r_wr_valid;
   logic [AW-1:0]   r_wr_adr;
   logic [DW-1:0]   r_wr_dat;

   logic            w_req;
   logic            w_idle;
   logic            w_go_ack;
   logic            w_err;
   logic [AW-1:0]   w_adr;
   logic [SW-1:0]   w_sel;
   logic            w_we;
   logic [DW-1:0]   w_dat;
   logic            w_is_data;
   logic [MW-1:0]   w_mem_idx;
   logic [DW-1:0]   w_inst_rd;
   logic            w_not_full;
   logic            w_pop;
   logic            w_push;

   // The commit happens on the edge entering ACK; from IDLE the request is still on the bus.
   assign w_req      = i_wb_cyc & i_wb_stb;
   assign w_idle     = (r_state == S_IDLE);
   assign w_adr      = w_idle ? i_wb_adr : r_adr;
   assign w_sel      = w_idle ? i_wb_sel : r_sel;
   assign w_we       = w_idle ? i_wb_we  : r_we;
   assign w_dat      = w_idle ? i_wb_dat : r_dat;
   assign w_is_data  = (w_adr >= i_data_base);
   assign w_mem_idx  = w_adr[BOFF +: MW];
   assign w_not_full = (r_count < CW'(FIFO_DEPTH));
   assign w_pop      = w_go_ack & ~w_err & ~w_is_data & ~w_we & (r_count != {CW{1'b0}});
   assign w_push     = i_inst_valid & (w_not_full | w_pop);

`ifdef WB_RESP_ERR_INJECT_EN
   logic r_err_lat;
   logic r_wb_err;

   // Error request is captured together with the rest of the request.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_err_lat <= 1'b0;
         r_wb_err  <= 1'b0;
      end else begin
         if (w_idle && w_req) r_err_lat <= i_err_req;
         else                 r_err_lat <= r_err_lat;
         r_wb_err <= w_go_ack & w_err;
      end
   end

   assign w_err    = w_idle ? i_err_req : r_err_lat;
   assign o_wb_err = r_wb_err;
`else
   assign w_err    = 1'b0;
   assign o_wb_err = 1'b0;
`endif

   // Decide whether this edge moves the FSM into ACK.
   always_comb begin
      w_go_ack = 1'b0;
      case (r_state)
         S_IDLE:  if (w_req && (WAIT_CYCLES == 0)) w_go_ack = 1'b1; else w_go_ack = 1'b0;
         S_WAIT:  if (i_wb_cyc && (r_cnt == 4'd1)) w_go_ack = 1'b1; else w_go_ack = 1'b0;
         default: w_go_ack = 1'b0;
      endcase
   end

   // Instruction beat: FIFO head (or filler) in lane 0, filler in every upper lane.
   always_comb begin
      w_inst_rd = {LANES{NOP_WORD}};
      if (r_count != {CW{1'b0}}) w_inst_rd[31:0] = r_fifo[r_rd_ptr];
      else                       w_inst_rd[31:0] = NOP_WORD;
   end

   // Transfer FSM and request latch.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_adr   <= {AW{1'b0}};
         r_sel   <= {SW{1'b0}};
         r_we    <= 1'b0;
         r_dat   <= {DW{1'b0}};
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  r_adr <= i_wb_adr;
                  r_sel <= i_wb_sel;
                  r_we  <= i_wb_we;
                  r_dat <= i_wb_dat;
                  if (WAIT_CYCLES == 0) begin
                     r_state <= S_ACK;
                  end else begin
                     r_state <= S_WAIT;
                     r_cnt   <= 4'(WAIT_CYCLES);
                  end
               end
            end
            S_WAIT: begin
               if (!i_wb_cyc) begin
                  r_state <= S_IDLE;
                  r_cnt   <= 4'd0;
               end else if (r_cnt == 4'd1) begin
                  r_state <= S_ACK;
                  r_cnt   <= 4'd0;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_ACK:   r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Bus response, data memory and committed-write report.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wb_ack   <= 1'b0;
         r_wb_dat   <= {DW{1'b0}};
         r_wr_valid <= 1'b0;
         r_wr_adr   <= {AW{1'b0}};
         r_wr_dat   <= {DW{1'b0}};
         for (int i = 0; i < MEM_WORDS; i++) r_mem[i] <= {DW{1'b0}};
      end else begin
         r_wb_ack   <= w_go_ack & ~w_err;
         r_wr_valid <= 1'b0;
         if (w_go_ack) begin
            if (w_err) begin
               r_wb_dat <= {DW{1'b0}};
            end else if (w_is_data) begin
               r_wb_dat <= r_mem[w_mem_idx];
               if (w_we) begin
                  for (int b = 0; b < SW; b++) begin
                     if (w_sel[b]) r_mem[w_mem_idx][b*8 +: 8] <= w_dat[b*8 +: 8];
                  end
                  r_wr_valid <= 1'b1;
                  r_wr_adr   <= w_adr;
                  r_wr_dat   <= w_dat;
               end
            end else begin
               r_wb_dat <= w_inst_rd;
            end
         end
      end
   end

   // Instruction FIFO; a pop frees its slot for a push on the same edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd_ptr <= {PW{1'b0}};
         r_wr_ptr <= {PW{1'b0}};
         r_count  <= {CW{1'b0}};
         for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= 32'h0;
      end else begin
         if (w_push) begin
            r_fifo[r_wr_ptr] <= i_inst;
            r_wr_ptr         <= r_wr_ptr + PW'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_wb_ack     = r_wb_ack;
   assign o_wb_dat     = r_wb_dat;
   assign o_wr_valid   = r_wr_valid;
   assign o_wr_adr     = r_wr_adr;
   assign o_wr_dat     = r_wr_dat;
   assign o_fifo_count = r_count;
   assign o_inst_ready = w_not_full;

endmodule

// File: tb/tb_wb_inst_responder.sv
// Self-checking bench for wb_inst_responder: one instance with no wait states, one with three.
module tb_wb_inst_responder;
   localparam logic [31:0] NOP  = 32'hF0801003;
   localparam logic [31:0] BASE = 32'h0000_0100;

   logic clk = 1'b0;
   logic rst_n;
   logic sel3;
   logic [31:0] adr;
   logic [15:0] bsel;
   logic we;
   logic [127:0] wdat;
   logic cyc, stb, ival;
   logic [31:0] inst;
   logic [31:0] base;
`ifdef WB_RESP_ERR_INJECT_EN
   logic err_req;
`endif

   logic [127:0] dat0, dat3, wrdat0, wrdat3;
   logic ack0, ack3, err0, err3, rdy0, rdy3, wrv0, wrv3;
   logic [3:0] cnt0, cnt3;
   logic [31:0] wradr0, wradr3;

   logic [127:0] m_dat, m_wrdat;
   logic m_ack, m_err, m_rdy, m_wrv;
   logic [3:0] m_cnt;
   logic [31:0] m_wradr;

   always #5 clk = ~clk;

   assign m_dat   = sel3 ? dat3   : dat0;
   assign m_wrdat = sel3 ? wrdat3 : wrdat0;
   assign m_ack   = sel3 ? ack3   : ack0;
   assign m_err   = sel3 ? err3   : err0;
   assign m_rdy   = sel3 ? rdy3   : rdy0;
   assign m_wrv   = sel3 ? wrv3   : wrv0;
   assign m_cnt   = sel3 ? cnt3   : cnt0;
   assign m_wradr = sel3 ? wradr3 : wradr0;

   wb_inst_responder #(.DW(128), .AW(32), .FIFO_DEPTH(8), .MEM_WORDS(16), .WAIT_CYCLES(0)) dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_wb_adr(adr), .i_wb_sel(bsel), .i_wb_we(we), .i_wb_dat(wdat),
      .i_wb_cyc(cyc & ~sel3), .i_wb_stb(stb & ~sel3), .o_wb_dat(dat0), .o_wb_ack(ack0), .o_wb_err(err0),
      .i_data_base(base), .i_inst_valid(ival & ~sel3), .i_inst(inst), .o_inst_ready(rdy0),
      .o_fifo_count(cnt0), .o_wr_valid(wrv0), .o_wr_adr(wradr0), .o_wr_dat(wrdat0)
`ifdef WB_RESP_ERR_INJECT_EN
      , .i_err_req(err_req)
`endif
   );

   wb_inst_responder #(.DW(128), .AW(32), .FIFO_DEPTH(8), .MEM_WORDS(16), .WAIT_CYCLES(3)) dut3 (
      .i_clk(clk), .i_rst_n(rst_n), .i_wb_adr(adr), .i_wb_sel(bsel), .i_wb_we(we), .i_wb_dat(wdat),
      .i_wb_cyc(cyc & sel3), .i_wb_stb(stb & sel3), .o_wb_dat(dat3), .o_wb_ack(ack3), .o_wb_err(err3),
      .i_data_base(base), .i_inst_valid(ival & sel3), .i_inst(inst), .o_inst_ready(rdy3),
      .o_fifo_count(cnt3), .o_wr_valid(wrv3), .o_wr_adr(wradr3), .o_wr_dat(wrdat3)
`ifdef WB_RESP_ERR_INJECT_EN
      , .i_err_req(err_req)
`endif
   );

   // Reference model: per-instance instruction queue and data memory.
   logic [31:0]  mq [2][$];
   logic [127:0] mm [2][16];
   int nerr = 0;
   int nchk = 0;

   typedef struct {
      bit           w;
      logic [31:0]  a;
      logic [15:0]  s;
      logic [127:0] d;
      logic [127:0] exp;
   } vec_t;
   vec_t tbl [13];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int d = 0; d < 2; d++) begin
         mq[d].delete();
         for (int i = 0; i < 16; i++) mm[d][i] = 128'h0;
      end
   endfunction

   task automatic push(input logic [31:0] w);
      int di;
      di = sel3 ? 1 : 0;
      chk("inst_ready", m_rdy, mq[di].size() < 8);
      ival = 1'b1; inst = w;
      tick();
      ival = 1'b0;
      if (mq[di].size() < 8) mq[di].push_back(w);
      chk("push_count", m_cnt, mq[di].size());
   endtask

   task automatic bus(input bit w_i, input logic [31:0] a, input logic [15:0] s, input logic [127:0] d,
                      input bit e, input bit use_t, input logic [127:0] t);
      int di, n, idx;
      bit got, is_data;
      logic [127:0] exp_rd, mask, seen;
      di      = sel3 ? 1 : 0;
      is_data = (a >= BASE);
      idx     = int'((a >> 4) % 32'd16);
      if (is_data)                exp_rd = mm[di][idx];
      else if (mq[di].size() > 0) exp_rd = {NOP, NOP, NOP, mq[di][0]};
      else                        exp_rd = {4{NOP}};
      adr = a; bsel = s; we = w_i; wdat = d; cyc = 1'b1; stb = 1'b1;
`ifdef WB_RESP_ERR_INJECT_EN
      err_req = e;
`endif
      n = 0; got = 1'b0;
      while (!got && n < 20) begin
         tick();
         n++;
         got = m_ack | m_err;
      end
      chk("ack_latency", n, sel3 ? 4 : 1);
      chk(e ? "err_pulse" : "ack_pulse", {m_err, m_ack}, e ? 2'b10 : 2'b01);
      seen = m_dat;
      if (!w_i && !e) begin
         chk("rd_data", m_dat, exp_rd);
         if (use_t) chk("tbl_data", m_dat, t);
      end
      if (w_i && is_data && !e) begin
         chk("wr_valid", m_wrv, 1'b1);
         chk("wr_adr", m_wradr, a);
         chk("wr_dat", m_wrdat, d);
         mask = 128'h0;
         for (int b = 0; b < 16; b++) if (s[b]) mask = mask | (128'hFF << (8 * b));
         mm[di][idx] = (mm[di][idx] & ~mask) | (d & mask);
      end else begin
         chk("wr_valid_none", m_wrv, 1'b0);
      end
      if (!w_i && !is_data && !e && mq[di].size() > 0) void'(mq[di].pop_front());
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
`ifdef WB_RESP_ERR_INJECT_EN
      err_req = 1'b0;
`endif
      tick();
      chk("ack_one_cycle", {m_err, m_ack}, 2'b00);
      chk("wr_valid_pulse", m_wrv, 1'b0);
      chk("dat_hold", m_dat, seen);
      chk("fifo_count", m_cnt, mq[di].size());
   endtask

   initial begin
      int sz;
      logic [127:0] rd;
      tbl[0]  = '{1'b1, 32'h110, 16'h000F, 128'h11111111_22222222_33333333_DEADBEEF, 128'h0};
      tbl[1]  = '{1'b0, 32'h110, 16'h0000, 128'h0, 128'h00000000_00000000_00000000_DEADBEEF};
      tbl[2]  = '{1'b1, 32'h114, 16'hF000, 128'hCAFEBABE_44444444_55555555_66666666, 128'h0};
      tbl[3]  = '{1'b0, 32'h11C, 16'h0000, 128'h0, 128'hCAFEBABE_00000000_00000000_DEADBEEF};
      tbl[4]  = '{1'b1, 32'h210, 16'h00F0, 128'h77777777_88888888_12345678_99999999, 128'h0};
      tbl[5]  = '{1'b0, 32'h110, 16'h0000, 128'h0, 128'hCAFEBABE_00000000_12345678_DEADBEEF};
      tbl[6]  = '{1'b0, 32'h120, 16'h0000, 128'h0, 128'h0};
      tbl[7]  = '{1'b1, 32'h1F0, 16'hFFFF, 128'h01234567_89ABCDEF_FEDCBA98_76543210, 128'h0};
      tbl[8]  = '{1'b0, 32'h1F8, 16'h0000, 128'h0, 128'h01234567_89ABCDEF_FEDCBA98_76543210};
      tbl[9]  = '{1'b1, 32'h1F0, 16'h0001, 128'h000000FF, 128'h0};
      tbl[10] = '{1'b0, 32'h1F0, 16'h0000, 128'h0, 128'h01234567_89ABCDEF_FEDCBA98_765432FF};
      tbl[11] = '{1'b0, 32'h100, 16'h0000, 128'h0, 128'h0};
      tbl[12] = '{1'b0, 32'h0FC, 16'h0000, 128'h0, {4{NOP}}};

      rst_n = 1'b0; sel3 = 1'b0; adr = 32'h0; bsel = 16'h0; we = 1'b0; wdat = 128'h0;
      cyc = 1'b0; stb = 1'b0; ival = 1'b0; inst = 32'h0; base = BASE;
`ifdef WB_RESP_ERR_INJECT_EN
      err_req = 1'b0;
`endif
      model_reset();
      tick(); tick();
      chk("rst_ack", {ack0, ack3, err0, err3, wrv0, wrv3}, 6'b0);
      chk("rst_count", {cnt0, cnt3}, 8'h00);
      chk("rst_ready", {rdy0, rdy3}, 2'b11);
      chk("rst_dat", dat0 | dat3 | wrdat0 | wrdat3, 128'h0);
      chk("rst_wradr", {wradr0, wradr3}, 64'h0);
      rst_n = 1'b1;
      tick();

      // Directed data-memory table on the three-wait-state instance.
      sel3 = 1'b1;
      for (int i = 0; i < 13; i++) bus(tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].d, 1'b0, !tbl[i].w, tbl[i].exp);

      // Single fetch and empty fetch with zero wait states.
      sel3 = 1'b0;
      push(32'hE3A01005);
      bus(1'b0, 32'h0, 16'hFFFF, 128'h0, 1'b0, 1'b1, {96'hF0801003F0801003F0801003, 32'hE3A01005});
      bus(1'b0, 32'h40, 16'hFFFF, 128'h0, 1'b0, 1'b1, {4{NOP}});
      bus(1'b1, 32'h20, 16'hFFFF, 128'h5, 1'b0, 1'b0, 128'h0);

      // Overfill, then push and pop on the same edge while full.
      for (int i = 0; i < 9; i++) push(32'hA000_0000 + i);
      chk("full_ready", m_rdy, 1'b0);
      chk("full_count", m_cnt, 4'd8);
      rd = {NOP, NOP, NOP, mq[0][0]};
      adr = 32'h0; we = 1'b0; cyc = 1'b1; stb = 1'b1; ival = 1'b1; inst = 32'h55AA0001;
      tick();
      ival = 1'b0; cyc = 1'b0; stb = 1'b0;
      chk("full_pp_ack", m_ack, 1'b1);
      chk("full_pp_dat", m_dat, rd);
      void'(mq[0].pop_front());
      mq[0].push_back(32'h55AA0001);
      tick();
      chk("full_pp_count", m_cnt, 4'd8);
      for (int i = 0; i < 8; i++) bus(1'b0, 32'h8, 16'hFFFF, 128'h0, 1'b0, 1'b0, 128'h0);

`ifdef WB_RESP_ERR_INJECT_EN
      push(32'h11112222);
      push(32'h33334444);
      bus(1'b0, 32'h0, 16'hFFFF, 128'h0, 1'b1, 1'b0, 128'h0);
      chk("err_count", m_cnt, 4'd2);
      bus(1'b0, 32'h0, 16'hFFFF, 128'h0, 1'b0, 1'b1, {NOP, NOP, NOP, 32'h11112222});
      bus(1'b0, 32'h0, 16'hFFFF, 128'h0, 1'b0, 1'b1, {NOP, NOP, NOP, 32'h33334444});
`endif

      // Random traffic on both instances against the model.
      for (int dsel = 0; dsel < 2; dsel++) begin
         sel3 = (dsel == 1);
         for (int k = 0; k < 60; k++) begin
            int op;
            op = $urandom_range(0, 4);
            case (op)
               0: push($urandom);
               1: bus(1'b0, $urandom_range(0, 255), 16'hFFFF, 128'h0, 1'b0, 1'b0, 128'h0);
               2: bus(1'b0, 32'h100 + $urandom_range(0, 1023), 16'h0, 128'h0, 1'b0, 1'b0, 128'h0);
               3: bus(1'b1, 32'h100 + $urandom_range(0, 1023), 16'($urandom),
                      {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, 128'h0);
               default: bus(1'b1, $urandom_range(0, 255), 16'hFFFF, {4{$urandom}}, 1'b0, 1'b0, 128'h0);
            endcase
         end
      end

      // Abort in WAIT, then reset in WAIT, on the three-wait-state instance.
      sel3 = 1'b1;
      push(32'hBEEF0001);
      push(32'hBEEF0002);
      sz = mq[1].size();
      adr = 32'h0; we = 1'b0; cyc = 1'b1; stb = 1'b1;
      tick(); tick();
      cyc = 1'b0; stb = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("abort_no_ack", {m_ack, m_err, m_wrv}, 3'b000);
      end
      chk("abort_count", m_cnt, sz);
      cyc = 1'b1; stb = 1'b1;
      tick(); tick();
      rst_n = 1'b0;
      #1;
      chk("rst_wait_ack", {m_ack, m_err}, 2'b00);
      chk("rst_wait_count", m_cnt, 4'd0);
      chk("rst_wait_ready", m_rdy, 1'b1);
      cyc = 1'b0; stb = 1'b0;
      model_reset();
      tick();
      rst_n = 1'b1;
      tick();
      bus(1'b0, 32'h0, 16'hFFFF, 128'h0, 1'b0, 1'b1, {4{NOP}});
      bus(1'b0, 32'h110, 16'h0, 128'h0, 1'b0, 1'b1, 128'h0);
      sel3 = 1'b0;
      bus(1'b0, 32'h1F0, 16'h0, 128'h0, 1'b0, 1'b1, 128'h0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
